// File: rtl/fpu_ieee_to_fp80_conv.sv
// fpu_ieee_to_fp80_conv
//   Converts an IEEE-754 binary operand {sign, exp[EXP_W], frac[FRAC_W]} to the
//   80-bit extended format {sign, exp[14:0], int bit, frac[62:0]} on the 8087
//   load path. Zero, normal, infinity and NaN results are ready one cycle after
//   acceptance. Denormals are normalised one bit per cycle in the NORM state.
//   Signalling NaNs are quietened and keep their payload.
// Parameters
//   EXP_W   source exponent width (2..15)
//   FRAC_W  source fraction width (2..63)
// Ports
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready      source handshake
//   in_data                source operand
//   out_valid/out_ready    result handshake; out_data held while stalled
//   out_data               80-bit extended result
//   busy                   denormal normalisation in progress
//   exc_flags              {invalid, denormal}, present only when the
//                          FPU_CONV_EXC_EN macro is defined
module fpu_ieee_to_fp80_conv #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [79:0]             out_data,
  output logic                    busy
`ifdef FPU_CONV_EXC_EN
  ,
  output logic [1:0]              exc_flags
`endif
);

  localparam int          BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam logic [14:0] EXP_OFF = 15'(16383 - BIAS);
  localparam logic [63:0] QUIET   = 64'h4000_0000_0000_0000;

  typedef enum logic {IDLE, NORM} state_t;

  state_t r_state, w_state_nxt;

  logic              w_sign;
  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_exp_zero, w_exp_ones, w_frac_zero, w_is_denorm;
  logic [63:0]       w_mant_n, w_mant_d;
  logic [79:0]       w_result;
  logic              w_accept, w_load_direct, w_start_norm, w_load_norm;

  logic              r_sign;
  logic [14:0]       r_exp;
  logic [63:0]       r_mant;
  logic              r_out_valid;
  logic [79:0]       r_out_data;

  assign w_sign      = in_data[EXP_W+FRAC_W];
  assign w_exp       = in_data[FRAC_W +: EXP_W];
  assign w_frac      = in_data[FRAC_W-1:0];
  assign w_exp_zero  = (w_exp == '0);
  assign w_exp_ones  = (w_exp == '1);
  assign w_frac_zero = (w_frac == '0);
  assign w_is_denorm = w_exp_zero && !w_frac_zero;

  // Explicit integer bit above the fraction, fraction left-aligned below it.
  assign w_mant_n = 64'({1'b1, w_frac}) << (63 - FRAC_W);
  // Denormal: the fraction starts left-aligned at bit 63 and is shifted up
  // until its leading one reaches the integer-bit position.
  assign w_mant_d = 64'(w_frac) << (64 - FRAC_W);

  // Single-cycle classes. Inf and NaN share the normal mantissa layout. The
  // fraction MSB lands on bit 62, so OR-ing QUIET forces the quiet bit.
  always_comb begin
    w_result = {w_sign, 15'(w_exp) + EXP_OFF, w_mant_n};
    if (w_exp_zero) begin
      w_result = {w_sign, 79'd0};
    end else if (w_exp_ones) begin
      w_result = {w_sign, 15'h7FFF, w_frac_zero ? w_mant_n : (w_mant_n | QUIET)};
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_norm) w_state_nxt = NORM;
      NORM:    if (w_load_norm)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    in_ready      = (r_state == IDLE) && (!r_out_valid || out_ready);
    busy          = (r_state == NORM);
    w_accept      = in_valid && in_ready;
    w_load_direct = w_accept && !w_is_denorm;
    w_start_norm  = w_accept && w_is_denorm;
    w_load_norm   = (r_state == NORM) && r_mant[63];
  end

  // Normalisation work registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_mant <= '0;
    end else if (w_start_norm) begin
      r_sign <= w_sign;
      r_exp  <= EXP_OFF;
      r_mant <= w_mant_d;
    end else if ((r_state == NORM) && !r_mant[63]) begin
      r_mant <= r_mant << 1;
      r_exp  <= r_exp - 15'd1;
    end
  end

  // Single-entry output register. A NORM load never collides with a stalled
  // result because NORM is entered only through a completed handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load_direct) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
    end else if (w_load_norm) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {r_sign, r_exp, r_mant};
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef FPU_CONV_EXC_EN
  logic       w_snan;
  logic [1:0] r_exc;

  assign w_snan = w_exp_ones && !w_frac_zero && !w_frac[FRAC_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_exc <= 2'b00;
    else if (w_load_direct) r_exc <= {w_snan, 1'b0};
    else if (w_load_norm)   r_exc <= 2'b01;
  end

  assign exc_flags = r_exc;
`endif

endmodule
